// File: rtl/mac_result_fifo.sv
// Result FIFO behind the 8x8 MAC: captures {ovf, frame-last, f} per accepted result,
// first-word-fall-through valid/ready output, sticky drop flag. Optional MAC_RESULT_SAT_EN.
module mac_result_fifo #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic [15:0]              f_in,
  input  logic                     ovf_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [15:0]              out_data,
  output logic                     out_ovf,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef struct packed {
    logic        ovf;
    logic        last;
    logic [15:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] frame_cnt;
  logic          push, pop, last_tag;
  logic [15:0]   wr_data;

  assign pop      = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = valid_in & (~full | pop);
  assign last_tag = (frame_cnt == FW'(FRAME_LEN - 1));

`ifdef MAC_RESULT_SAT_EN
  // Sign of the last non-overflowed result picks the saturation rail.
  logic last_good_neg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                last_good_neg <= 1'b0;
    else if (push && !ovf_in) last_good_neg <= f_in[15];
  end
  assign wr_data = ovf_in ? (last_good_neg ? 16'h8000 : 16'h7FFF) : f_in;
`else
  assign wr_data = f_in;
`endif

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{ovf: ovf_in, last: last_tag, data: wr_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        frame_cnt <= last_tag ? '0 : frame_cnt + FW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (valid_in && !push) drop_err <= 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign out_data  = mem[rd_ptr].data;
  assign out_ovf   = mem[rd_ptr].ovf;
  assign out_last  = mem[rd_ptr].last;
endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo: vector table, corner sequences, random vs queue model.
module tb_mac_result_fifo;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 4;

  logic                   clk = 1'b0, reset = 1'b1;
  logic                   valid_in = 1'b0, ovf_in = 1'b0, out_ready = 1'b0;
  logic [15:0]            f_in = '0;
  logic                   out_valid, out_ovf, out_last, full, drop_err;
  logic [15:0]            out_data;
  logic [$clog2(DEPTH):0] count;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mac_result_fifo #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .f_in(f_in), .ovf_in(ovf_in),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
    .out_last(out_last), .count(count), .full(full), .drop_err(drop_err)
  );

  typedef struct {
    logic v; int f; logic o; logic r;
    logic ev; int ed; logic el; int ec;
  } vec_t;

  typedef struct {
    int   data;
    logic ovf;
    logic last;
  } ent_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input int f, input logic o, input logic r);
    valid_in = v; f_in = 16'(f); ovf_in = o; out_ready = r;
    @(posedge clk); #1;
    valid_in = 1'b0; out_ready = 1'b0;
  endtask

  task automatic rst_pulse;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_drop", drop_err, 0);
  endtask

  // Checks the head against the expected entry, then pops it.
  task automatic drain_chk(input string nm, input int d, input logic o, input logic l);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, int'($signed(out_data)), d);
    chk({nm, "_ovf"}, out_ovf, o);
    chk({nm, "_last"}, out_last, l);
    cyc(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Reference model state
  ent_t q[$];
  int   nacc;
  logic lgn, mdrop;

  function automatic int stored(input int f, input logic o);
`ifdef MAC_RESULT_SAT_EN
    if (o) return lgn ? -32768 : 32767;
`endif
    return int'($signed(16'(f)));
  endfunction

  vec_t tv[5];

  initial begin
    tv[0] = '{1'b1, 4,  1'b0, 1'b1, 1'b1, 4,  1'b0, 1};
    tv[1] = '{1'b1, 13, 1'b0, 1'b1, 1'b1, 13, 1'b0, 1};
    tv[2] = '{1'b1, 49, 1'b0, 1'b1, 1'b1, 49, 1'b0, 1};
    tv[3] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 0,  1'b0, 0};
    tv[4] = '{1'b0, 0,  1'b0, 1'b1, 1'b0, 0,  1'b0, 0};

    #12;
    chk("init_valid", out_valid, 0);
    chk("init_count", count, 0);
    @(posedge clk); #1;
    rst_pulse();

    // Streaming with ready high: valid only after the push edge, count stays <= 1
    chk("t1_pre_valid", out_valid, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(tv[i].v, tv[i].f, tv[i].o, tv[i].r);
      chk($sformatf("t1_valid%0d", i), out_valid, tv[i].ev);
      chk($sformatf("t1_count%0d", i), count, tv[i].ec);
      if (tv[i].ev) begin
        chk($sformatf("t1_data%0d", i), int'($signed(out_data)), tv[i].ed);
        chk($sformatf("t1_last%0d", i), out_last, tv[i].el);
      end
    end

    // Fill past full with a stalled consumer
    rst_pulse();
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, k, 1'b0, 1'b0);
      chk($sformatf("t2_count%0d", k), count, (k > 8) ? 8 : k);
      chk($sformatf("t2_full%0d", k), full, (k >= 8) ? 1 : 0);
      chk($sformatf("t2_drop%0d", k), drop_err, (k > 8) ? 1 : 0);
    end
    for (int k = 1; k <= 8; k++)
      drain_chk($sformatf("t2_e%0d", k), k, 1'b0, (k == 4 || k == 8));
    chk("t2_empty", out_valid, 0);
    chk("t2_drop_hold", drop_err, 1);

    // Full with simultaneous push and pop
    rst_pulse();
    for (int k = 0; k < 8; k++) cyc(1'b1, 10 + k, 1'b0, 1'b0);
    chk("t3_full", full, 1);
    cyc(1'b1, 99, 1'b0, 1'b1);
    chk("t3_count", count, 8);
    chk("t3_drop", drop_err, 0);
    for (int k = 1; k < 8; k++)
      drain_chk($sformatf("t3_e%0d", k), 10 + k, 1'b0, (k == 3 || k == 7));
    drain_chk("t3_new", 99, 1'b0, 1'b0);

    // Overflow tagging / saturation, positive history
    rst_pulse();
    cyc(1'b1, 30000, 1'b0, 1'b0);
    cyc(1'b1, 25000, 1'b1, 1'b0);
    cyc(1'b1, -20000, 1'b1, 1'b0);
    drain_chk("t4_a", 30000, 1'b0, 1'b0);
`ifdef MAC_RESULT_SAT_EN
    drain_chk("t4_b", 32767, 1'b1, 1'b0);
    drain_chk("t4_c", 32767, 1'b1, 1'b0);
`else
    drain_chk("t4_b", 25000, 1'b1, 1'b0);
    drain_chk("t4_c", -20000, 1'b1, 1'b0);
`endif

    // Negative history
    rst_pulse();
    cyc(1'b1, -5, 1'b0, 1'b0);
    cyc(1'b1, 100, 1'b1, 1'b0);
    drain_chk("t5_a", -5, 1'b0, 1'b0);
`ifdef MAC_RESULT_SAT_EN
    drain_chk("t5_b", -32768, 1'b1, 1'b0);
`else
    drain_chk("t5_b", 100, 1'b1, 1'b0);
`endif

    // Mid-cycle asynchronous reset with 3 entries held and drop_err set
    rst_pulse();
    for (int k = 0; k < 9; k++) cyc(1'b1, 50 + k, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 0, 1'b0, 1'b1);
    chk("t6_pre_count", count, 3);
    chk("t6_pre_drop", drop_err, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_count", count, 0);
    chk("t6_async_drop", drop_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b1, 7, 1'b0, 1'b0);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", int'($signed(out_data)), 7);
    chk("t6_last", out_last, 0);
    cyc(1'b1, 8, 1'b0, 1'b0);
    cyc(1'b1, 9, 1'b0, 1'b0);
    cyc(1'b1, 10, 1'b0, 1'b0);
    drain_chk("t6_e1", 7, 1'b0, 1'b0);
    drain_chk("t6_e2", 8, 1'b0, 1'b0);
    drain_chk("t6_e3", 9, 1'b0, 1'b0);
    drain_chk("t6_e4", 10, 1'b0, 1'b1);

    // Random traffic against the queue model; ready bias alternates to reach full/drop
    rst_pulse();
    q.delete(); nacc = 0; lgn = 1'b0; mdrop = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic v, o, r, pop, push;
      int   f;
      ent_t e;
      v = ($urandom_range(0, 3) != 0);
      f = int'($signed(16'($urandom)));
      o = ($urandom_range(0, 5) == 0);
      r = (((i / 150) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      pop  = (q.size() > 0) && r;
      push = v && ((q.size() < DEPTH) || pop);
      if (pop) void'(q.pop_front());
      if (push) begin
        e.data = stored(f, o);
        e.ovf  = o;
        e.last = ((nacc % FRAME_LEN) == FRAME_LEN - 1);
        nacc++;
        if (!o) lgn = f[15];
        q.push_back(e);
      end else if (v) mdrop = 1'b1;
      cyc(v, f, o, r);
      chk("rnd_count", count, q.size());
      chk("rnd_valid", out_valid, (q.size() != 0));
      chk("rnd_full", full, (q.size() == DEPTH));
      chk("rnd_drop", drop_err, mdrop);
      if (q.size() != 0) begin
        chk("rnd_data", int'($signed(out_data)), q[0].data);
        chk("rnd_ovf", out_ovf, q[0].ovf);
        chk("rnd_last", out_last, q[0].last);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
